mem_io_responder: RTL and testbench



---
 rtl/mem_io_pkg.sv | 31 +++
 rtl/byte_fifo.sv | 53 +++++
 rtl/mem_io_responder.sv | 135 +++++++++++++
 tb/tb_mem_io_responder.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared decode constants for the memory/IO responder.
// IO window lives at mem_a[17:16] == 2'b11.
package mem_io_pkg;

    localparam logic [1:0]  IO_BASE_HI     = 2'b11;
    localparam logic [17:0] UART_DATA_ADDR = 18'h30000;
    localparam logic [17:0] UART_STAT_ADDR = 18'h30004;

    localparam int STAT_RX_AVAIL_BIT = 0;
    localparam int STAT_TX_FULL_BIT  = 1;

    typedef enum logic [1:0] {
        ACC_RAM,
        ACC_DATA,
        ACC_STAT,
        ACC_NONE
    } acc_e;

    function automatic acc_e decode_acc(input logic [17:0] a);
        acc_e acc;
        acc = ACC_NONE;
        unique case (1'b1)
            a[17:16] != IO_BASE_HI: acc = ACC_RAM;
            a == UART_DATA_ADDR:    acc = ACC_DATA;
            a == UART_STAT_ADDR:    acc = ACC_STAT;
            default:                acc = ACC_NONE;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO with a combinational head.
// Pushes into a full FIFO are dropped; pops from an empty one are ignored.
module byte_fifo #(
    parameter int DEPTH = 16,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt,
    output logic [7:0]    head
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide bus responder backing RAM and the
// UART TX/RX FIFOs plus halt flag in the 0x3xxxx window.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 17,
  parameter string INIT_FILE   = "",
  parameter int    TX_DEPTH    = 16,
  parameter int    RX_DEPTH    = 16,
  parameter int    FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        sim_halt,
  output logic        tx_overflow
);

  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam logic [TCW-1:0] FULL_LVL =
    TCW'(TX_DEPTH - FULL_MARGIN);

  logic [7:0] ram [2**ADDR_WIDTH];

  acc_e                  acc;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  ram_we;
  logic                  tx_push;
  logic                  tx_pop;
  logic                  tx_full;
  logic                  tx_empty;
  logic [TCW-1:0]        tx_count_unused;
  logic [TCW-1:0]        tx_count_nxt;
  logic                  rx_push;
  logic                  rx_pop;
  logic                  rx_full;
  logic                  rx_empty;
  logic [7:0]            rx_head;
  logic [RCW-1:0]        rx_count_unused;
  logic [RCW-1:0]        rx_count_nxt_unused;
  logic [7:0]            stat;
  logic                  unused_bits;

  assign acc     = decode_acc(mem_a[17:0]);
  assign ram_idx = mem_a[ADDR_WIDTH-1:0];
  assign ram_we  = !rst_in && mem_wr &&
                   (acc == ACC_RAM);

  assign tx_push  = !rst_in && mem_wr &&
                    (acc == ACC_DATA);
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = !rst_in && !mem_wr &&
                    (acc == ACC_DATA);

  assign unused_bits = ^{mem_a[31:18],
                         tx_count_unused,
                         rx_count_unused,
                         rx_count_nxt_unused};

  always_comb begin
    stat = '0;
    stat[STAT_TX_FULL_BIT]  = io_buffer_full;
    stat[STAT_RX_AVAIL_BIT] = !rx_empty;
  end

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .din       (mem_dout),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count_unused),
    .count_nxt (tx_count_nxt),
    .head      (tx_data)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (rx_push),
    .din       (rx_data),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count_unused),
    .count_nxt (rx_count_nxt_unused),
    .head      (rx_head)
  );

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din        <= '0;
      io_buffer_full <= 1'b0;
      sim_halt       <= 1'b0;
      tx_overflow    <= 1'b0;
    end else begin
      io_buffer_full <= (tx_count_nxt >= FULL_LVL);
      if (mem_wr && (acc == ACC_STAT))
        sim_halt <= 1'b1;
      if (tx_push && tx_full)
        tx_overflow <= 1'b1;
      if (!mem_wr) begin
        unique case (acc)
          ACC_RAM:  mem_din <= ram[ram_idx];
          ACC_DATA: mem_din <= rx_empty ? 8'h00
                                        : rx_head;
          ACC_STAT: mem_din <= stat;
          default:  mem_din <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed scenarios plus randomized traffic
// checked against a queue-based model of the bus and UART FIFOs.
module tb_mem_io_responder;

    localparam int TXD    = 16;
    localparam int RXD    = 16;
    localparam int MARGIN = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] mem_a = 32'h0003000C;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = 8'h00;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        sim_halt;
    logic        tx_overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] m_ram[int];
    logic [7:0] m_din  = 8'h00;
    logic       m_halt = 1'b0;
    logic       m_ovf  = 1'b0;
    logic       m_iobf = 1'b0;

    mem_io_responder #(
        .ADDR_WIDTH  (17),
        .INIT_FILE   (""),
        .TX_DEPTH    (TXD),
        .RX_DEPTH    (RXD),
        .FULL_MARGIN (MARGIN)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .sim_halt       (sim_halt),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Model applies one bus cycle from the current inputs.
    task automatic model_step();
        logic [17:0] a;
        logic [7:0]  popped;
        bit io, tx_pop, rx_push, tx_push;
        if (rst_in) begin
            tx_q.delete();
            rx_q.delete();
            m_din = 8'h00; m_halt = 0; m_ovf = 0; m_iobf = 0;
            return;
        end
        a = mem_a[17:0];
        io = (a[17:16] == 2'b11);
        tx_pop  = (tx_q.size() != 0) && tx_ready;
        rx_push = rx_valid && (rx_q.size() < RXD);
        tx_push = 0;
        if (mem_wr) begin
            if (!io) m_ram[int'(a[16:0])] = mem_dout;
            else if (a == 18'h30000) begin
                if (tx_q.size() == TXD) m_ovf = 1;
                else tx_push = 1;
            end else if (a == 18'h30004) m_halt = 1;
        end else begin
            if (!io)
                m_din = m_ram.exists(int'(a[16:0])) ? m_ram[int'(a[16:0])] : 8'h00;
            else if (a == 18'h30000) begin
                if (rx_q.size() != 0) begin
                    popped = rx_q.pop_front();
                    m_din = popped;
                end else m_din = 8'h00;
            end else if (a == 18'h30004)
                m_din = {6'b0, m_iobf, rx_q.size() != 0};
            else m_din = 8'h00;
        end
        if (tx_pop) void'(tx_q.pop_front());
        if (tx_push) tx_q.push_back(mem_dout);
        if (rx_push) rx_q.push_back(rx_data);
        m_iobf = (tx_q.size() >= TXD - MARGIN);
    endtask

    task automatic step();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        mem_wr = 0; mem_a = 32'h0003000C; mem_dout = 8'h00;
        tx_ready = 0; rx_valid = 0; rst_in = 0;
    endtask

    task automatic bus(input bit wr, input logic [17:0] a, input logic [7:0] d);
        mem_wr = wr; mem_a = {14'h0, a}; mem_dout = d;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1; step();
        rst_in = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1; step(); step();
        checks++;
        if (mem_din !== 8'h00 || tx_valid !== 1'b0 || rx_ready !== 1'b1 ||
            io_buffer_full !== 1'b0 || sim_halt !== 1'b0 || tx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: din=%h txv=%b rxr=%b iobf=%b halt=%b ovf=%b",
                     mem_din, tx_valid, rx_ready, io_buffer_full, sim_halt, tx_overflow);
        end
        rst_in = 0;
    endtask

    task automatic test_ram_latency();
        bus(1, 18'h00010, 8'hA5); step();
        bus(1, 18'h00011, 8'h5A); step();
        bus(0, 18'h00011, 8'h00); step();
        checks++;
        if (mem_din !== 8'h5A) begin
            errors++; $display("FAIL ram_read11: got %h exp 5a", mem_din);
        end
        bus(1, 18'h00012, 8'h33); step();
        checks++;
        if (mem_din !== 8'h5A) begin
            errors++; $display("FAIL ram_wr_hold: got %h exp 5a", mem_din);
        end
        bus(0, 18'h00010, 8'h00); step();
        checks++;
        if (mem_din !== 8'hA5) begin
            errors++; $display("FAIL ram_read10: got %h exp a5", mem_din);
        end
        idle();
    endtask

    task automatic test_tx_path();
        do_reset();
        bus(1, 18'h30000, 8'h41); step();
        bus(1, 18'h30000, 8'h42); step();
        idle(); step();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            errors++; $display("FAIL tx_head: v=%b d=%h exp 1/41", tx_valid, tx_data);
        end
        tx_ready = 1; step();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin
            errors++; $display("FAIL tx_second: v=%b d=%h exp 1/42", tx_valid, tx_data);
        end
        step();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL tx_drained: v=%b exp 0", tx_valid);
        end
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            bus(1, 18'h30000, 8'h10 + 8'(i)); step();
            if (i == 12) begin
                checks++;
                if (io_buffer_full !== 1'b0) begin
                    errors++; $display("FAIL iobf_13: got %b exp 0", io_buffer_full);
                end
            end
        end
        checks++;
        if (io_buffer_full !== 1'b1) begin
            errors++; $display("FAIL iobf_14: got %b exp 1", io_buffer_full);
        end
        bus(1, 18'h30000, 8'h1E); step();
        bus(1, 18'h30000, 8'h1F); step();
        checks++;
        if (tx_overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_16: got %b exp 0", tx_overflow);
        end
        bus(1, 18'h30000, 8'hEE); step();
        checks++;
        if (tx_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_17: got %b exp 1", tx_overflow);
        end
        idle(); tx_ready = 1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL drain_%0d: v=%b d=%h exp 1/%h", i, tx_valid, tx_data, 8'h10 + 8'(i));
            end
            step();
        end
        checks++;
        if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0 || tx_overflow !== 1'b1) begin
            errors++;
            $display("FAIL drain_end: v=%b iobf=%b ovf=%b exp 0/0/1", tx_valid, io_buffer_full, tx_overflow);
        end
        idle();
    endtask

    task automatic test_rx_path();
        do_reset();
        rx_valid = 1; rx_data = 8'h31; step();
        rx_valid = 0;
        bus(0, 18'h30004, 8'h00); step();
        checks++;
        if (mem_din !== 8'h01) begin
            errors++; $display("FAIL rx_stat1: got %h exp 01", mem_din);
        end
        bus(0, 18'h30000, 8'h00); step();
        checks++;
        if (mem_din !== 8'h31) begin
            errors++; $display("FAIL rx_read: got %h exp 31", mem_din);
        end
        step();
        checks++;
        if (mem_din !== 8'h00) begin
            errors++; $display("FAIL rx_empty_read: got %h exp 00", mem_din);
        end
        bus(0, 18'h30004, 8'h00); step();
        checks++;
        if (mem_din !== 8'h00) begin
            errors++; $display("FAIL rx_stat0: got %h exp 00", mem_din);
        end
        idle();
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus(1, 18'h30000, 8'h50 + 8'(i)); step();
        end
        bus(1, 18'h30000, 8'h55); tx_ready = 1; step();
        idle(); tx_ready = 1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h51 + 8'(i)) begin
                errors++;
                $display("FAIL simul_tx_%0d: v=%b d=%h exp 1/%h", i, tx_valid, tx_data, 8'h51 + 8'(i));
            end
            step();
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL simul_tx_end: v=%b exp 0", tx_valid);
        end
        idle();
        for (int i = 0; i < RXD; i++) begin
            rx_valid = 1; rx_data = 8'h60 + 8'(i); step();
        end
        rx_valid = 0;
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++; $display("FAIL rx_full: rx_ready=%b exp 0", rx_ready);
        end
        bus(0, 18'h30000, 8'h00); step();
        checks++;
        if (rx_ready !== 1'b1 || mem_din !== 8'h60) begin
            errors++; $display("FAIL rx_pop_full: rdy=%b d=%h exp 1/60", rx_ready, mem_din);
        end
        do_reset();
        rx_valid = 1; rx_data = 8'h99; bus(0, 18'h30000, 8'h00); step();
        rx_valid = 0;
        checks++;
        if (mem_din !== 8'h00) begin
            errors++; $display("FAIL rx_same_cycle: got %h exp 00", mem_din);
        end
        step();
        checks++;
        if (mem_din !== 8'h99) begin
            errors++; $display("FAIL rx_after: got %h exp 99", mem_din);
        end
        idle();
    endtask

    task automatic test_halt_reset();
        bus(1, 18'h30004, 8'h00); step();
        checks++;
        if (sim_halt !== 1'b1) begin
            errors++; $display("FAIL halt_set: got %b exp 1", sim_halt);
        end
        bus(1, 18'h00020, 8'h11); step();
        for (int i = 0; i < 3; i++) begin
            bus(1, 18'h30000, 8'h70 + 8'(i)); step();
        end
        bus(0, 18'h00010, 8'h00); step();
        rst_in = 1; bus(1, 18'h00020, 8'h99); step();
        rst_in = 0; bus(1, 18'h30004, 8'h00); rst_in = 1; step();
        rst_in = 0; idle();
        checks++;
        if (tx_valid !== 1'b0 || sim_halt !== 1'b0 || mem_din !== 8'h00) begin
            errors++;
            $display("FAIL post_reset: v=%b halt=%b d=%h exp 0/0/00", tx_valid, sim_halt, mem_din);
        end
        bus(0, 18'h00020, 8'h00); step();
        checks++;
        if (mem_din !== 8'h11) begin
            errors++; $display("FAIL ram_keep20: got %h exp 11", mem_din);
        end
        bus(0, 18'h00010, 8'h00); step();
        checks++;
        if (mem_din !== 8'hA5) begin
            errors++; $display("FAIL ram_keep10: got %h exp a5", mem_din);
        end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] r, r2;
        logic [17:0] a18;
        int rdy_pct;
        rdy_pct = 50;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus(1, 18'(i), 8'($urandom())); step();
        end
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) rdy_pct = $urandom_range(5, 95);
            r  = $urandom();
            r2 = $urandom();
            case (r[3:1])
                3'd0, 3'd1, 3'd2: a18 = {14'h0, r[7:4]};
                3'd3, 3'd4, 3'd5: a18 = 18'h30000;
                3'd6:             a18 = 18'h30004;
                default:          a18 = r[8] ? 18'h30008 : 18'h3FFFC;
            endcase
            rst_in   = ($urandom_range(0, 299) == 0);
            mem_wr   = r[0] && !(a18 == 18'h30004 && r[9]);
            mem_a    = {r2[13:0], a18};
            mem_dout = r[23:16];
            tx_ready = ($urandom_range(0, 99) < rdy_pct);
            rx_valid = ($urandom_range(0, 99) >= rdy_pct);
            rx_data  = r[31:24];
            step();
            checks++;
            if (mem_din !== m_din) begin
                errors++; $display("FAIL rnd_din @%0d: got %h exp %h", n, mem_din, m_din);
            end
            checks++;
            if (tx_valid !== (tx_q.size() != 0) ||
                (tx_q.size() != 0 && tx_data !== tx_q[0])) begin
                errors++;
                $display("FAIL rnd_tx @%0d: v=%b d=%h exp %0d entries", n, tx_valid, tx_data, tx_q.size());
            end
            checks++;
            if (rx_ready !== (rx_q.size() < RXD) || io_buffer_full !== m_iobf ||
                sim_halt !== m_halt || tx_overflow !== m_ovf) begin
                errors++;
                $display("FAIL rnd_flags @%0d: rdy=%b iobf=%b halt=%b ovf=%b exp %b/%b/%b/%b",
                         n, rx_ready, io_buffer_full, sim_halt, tx_overflow,
                         rx_q.size() < RXD, m_iobf, m_halt, m_ovf);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_ram_latency();
        test_tx_path();
        test_backpressure();
        test_rx_path();
        test_simultaneous();
        test_halt_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
